// File: rtl/decode_stage.sv
// Instruction decode stage feeding the ID/EX register; optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data.
// Latency: 1 cycle from accepted instruction to ex_valid; register-file addresses are driven combinationally from if_instr.
// Backpressure: if_ready drops on execute stall, load-use hazard, flush, reset, or (without bypass) a same-cycle writeback to a source.
module decode_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [DATA_W-1:0]     if_instr,
  output logic                  if_ready,
  output logic [REG_ADDR_W-1:0] rf_read_reg1,
  output logic [REG_ADDR_W-1:0] rf_read_reg2,
  input  logic [DATA_W-1:0]     rf_read_data1,
  input  logic [DATA_W-1:0]     rf_read_data2,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0]     wb_write_data,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [5:0]            ex_opcode,
  output logic [5:0]            ex_funct,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_dest_reg,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [REG_ADDR_W-1:0] dec_dest;
  logic                  dec_reg_write, dec_mem_read, uses_rt, zero_ext;
  logic [DATA_W-1:0]     imm_ext, rs_op, rt_op;
  logic                  wb_hit_rs, wb_hit_rt, wb_stall;
  logic                  hazard, advance, transfer;

  assign opcode       = if_instr[31:26];
  assign rs           = if_instr[25:21];
  assign rt           = if_instr[20:16];
  assign rd           = if_instr[15:11];
  assign rf_read_reg1 = rs;
  assign rf_read_reg2 = rt;

  // Opcode decode: destination, write/load flags, rt usage and immediate extension kind.
  always_comb begin
    dec_dest      = '0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    uses_rt       = 1'b0;
    zero_ext      = 1'b0;
    case (opcode)
      OP_RTYPE: begin dec_dest = rd; dec_reg_write = 1'b1; uses_rt = 1'b1; end
      OP_LW:    begin dec_dest = rt; dec_reg_write = 1'b1; dec_mem_read = 1'b1; end
      OP_SW,
      OP_BEQ:   uses_rt = 1'b1;
      OP_ADDI,
      OP_SLTI:  begin dec_dest = rt; dec_reg_write = 1'b1; end
      OP_ANDI,
      OP_ORI:   begin dec_dest = rt; dec_reg_write = 1'b1; zero_ext = 1'b1; end
      default:  ;
    endcase
  end

  assign imm_ext = zero_ext ? {{(DATA_W-16){1'b0}}, if_instr[15:0]}
                            : {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};

  // A writeback to register 0 never matches: $0 always reads as zero.
  assign wb_hit_rs = wb_reg_write && (wb_write_reg == rs) && (rs != '0);
  assign wb_hit_rt = wb_reg_write && (wb_write_reg == rt) && (rt != '0);

  // Operand selection; register 0 is forced to zero ahead of any bypass.
`ifdef DECODE_WB_BYPASS_EN
  always_comb begin
    wb_stall = 1'b0;
    rs_op    = (rs == '0) ? '0 : (wb_hit_rs ? wb_write_data : rf_read_data1);
    rt_op    = (rt == '0) ? '0 : (wb_hit_rt ? wb_write_data : rf_read_data2);
  end
`else
  // Without forwarding, wait one cycle so the register file holds the new value.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_write_data;
  always_comb begin
    wb_stall = wb_hit_rs || (uses_rt && wb_hit_rt);
    rs_op    = (rs == '0) ? '0 : rf_read_data1;
    rt_op    = (rt == '0) ? '0 : rf_read_data2;
  end
`endif

  assign hazard = ex_valid && ex_mem_read && (ex_dest_reg != '0) &&
                  ((ex_dest_reg == rs) || (uses_rt && (ex_dest_reg == rt)));

  assign advance  = !ex_valid || ex_ready;
  assign if_ready = !reset && advance && !hazard && !flush && !wb_stall;
  assign transfer = if_valid && if_ready;

  // ID/EX register: flush kills, accepted instruction loads, empty advance leaves a bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_funct     <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_dest_reg  <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      if (transfer) begin
        ex_valid     <= 1'b1;
        ex_opcode    <= opcode;
        ex_funct     <= if_instr[5:0];
        ex_rs_data   <= rs_op;
        ex_rt_data   <= rt_op;
        ex_imm       <= imm_ext;
        ex_dest_reg  <= dec_dest;
        ex_reg_write <= dec_reg_write && (dec_dest != '0);
        ex_mem_read  <= dec_mem_read;
      end else begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instructions, queued expectations, output monitor.
// A small register-file model supplies read data and absorbs writebacks.
// The monitor compares every instruction handed to execute (ex_valid & ex_ready).
module tb_decode_stage;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
  } exp_t;

  logic        clock, reset;
  logic        if_valid, if_ready;
  logic [31:0] if_instr;
  logic [4:0]  rf_read_reg1, rf_read_reg2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        flush, ex_ready, ex_valid;
  logic [5:0]  ex_opcode, ex_funct;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_dest_reg;
  logic        ex_reg_write, ex_mem_read;

  exp_t        act, mon_e;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] wr_en;
  logic [31:0] wr_val [32];

  decode_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_dest_reg(ex_dest_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register 0 holds garbage here so the stage's own zeroing of $0 is exercised.
  function automatic logic [31:0] init_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'hBAD0_BAD0 : (32'hC0DE_0000 | {27'd0, a});
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) wr_en <= '0;
    else if (wb_reg_write) begin
      wr_en[wb_write_reg]  <= 1'b1;
      wr_val[wb_write_reg] <= wb_write_data;
    end
  end

  always_comb begin
    rf_read_data1 = wr_en[rf_read_reg1] ? wr_val[rf_read_reg1] : init_val(rf_read_reg1);
    rf_read_data2 = wr_en[rf_read_reg2] ? wr_val[rf_read_reg2] : init_val(rf_read_reg2);
    act = {ex_opcode, ex_funct, ex_rs_data, ex_rt_data, ex_imm, ex_dest_reg, ex_reg_write, ex_mem_read};
  end

  function automatic exp_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [31:0] imm, input logic [4:0] dest,
                              input logic rw, input logic mr);
    return {op, fn, rs, rt, imm, dest, rw, mr};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: every handoff to execute must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && ex_valid && ex_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h want no output", act);
      end else begin
        mon_e = sb.pop_front();
        check("ex_output", 128'(act), 128'(mon_e));
      end
    end
  end

  task automatic send(input logic [31:0] ins, input exp_t e, input bit push,
                      output int waits, output logic vld_at);
    int n;
    n = 0;
    if_valid = 1'b1;
    if_instr = ins;
    @(negedge clock);
    while (!if_ready && n < 20) begin
      n++;
      @(negedge clock);
    end
    waits  = n;
    vld_at = ex_valid;
    if (!if_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got if_ready=0 want 1 within 20 cycles");
    end else if (push) sb.push_back(e);
    @(posedge clock);
    #1;
    if_valid = 1'b0;
  endtask

  task automatic vec(input string name, input logic [31:0] ins, input exp_t e, input int wexp);
    int   w;
    logic v;
    send(ins, e, 1'b1, w, v);
    check(name, 128'(w), 128'(wexp));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish before 100us");
    $fatal(1);
  end

  initial begin
    int   w;
    logic v;
    exp_t ea, eb;
    reset = 1'b1; if_valid = 1'b0; if_instr = '0; flush = 1'b0; ex_ready = 1'b1;
    wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0;

    @(negedge clock);
    check("reset_if_ready", 128'(if_ready), 128'(0));
    check("reset_ex_valid", 128'(ex_valid), 128'(0));
    reset = 1'b0;
    @(posedge clock); #1;

    // Load one instruction, hold it, then assert reset mid-cycle.
    ex_ready = 1'b0;
    send(32'h2005FFFD, '0, 1'b0, w, v);
    check("held_ex_valid", 128'(ex_valid), 128'(1));
    #2 reset = 1'b1;
    #1;
    check("async_reset_ex_valid", 128'(ex_valid), 128'(0));
    check("async_reset_fields", 128'(act), 128'(0));
    check("async_reset_if_ready", 128'(if_ready), 128'(0));
    @(negedge clock);
    reset = 1'b0;
    ex_ready = 1'b1;
    @(posedge clock); #1;

    // Decode and immediate extension.
    vec("addi_neg", 32'h2005FFFD, mk(6'h08, 6'h3D, 32'h0, init_val(5), 32'hFFFFFFFD, 5'd5, 1'b1, 1'b0), 0);
    vec("ori_zext", 32'h34068000, mk(6'h0D, 6'h00, 32'h0, init_val(6), 32'h00008000, 5'd6, 1'b1, 1'b0), 0);
    vec("add_dest0", 32'h00220020, mk(6'h00, 6'h20, init_val(1), init_val(2), 32'h00000020, 5'd0, 1'b0, 1'b0), 0);
    vec("andi_zext", 32'h306AFFFF, mk(6'h0C, 6'h3F, init_val(3), init_val(10), 32'h0000FFFF, 5'd10, 1'b1, 1'b0), 0);
    vec("slti_sext", 32'h284BFFFF, mk(6'h0A, 6'h3F, init_val(2), init_val(11), 32'hFFFFFFFF, 5'd11, 1'b1, 1'b0), 0);
    vec("unknown_op", 32'hFC221234, mk(6'h3F, 6'h34, init_val(1), init_val(2), 32'h00001234, 5'd0, 1'b0, 1'b0), 0);

    // Load-use on rs: one stall, one bubble.
    vec("lw_a", 32'h8C280000, mk(6'h23, 6'h00, init_val(1), init_val(8), 32'h0, 5'd8, 1'b1, 1'b1), 0);
    send(32'h01034820, mk(6'h00, 6'h20, init_val(8), init_val(3), 32'h00004820, 5'd9, 1'b1, 1'b0), 1'b1, w, v);
    check("loaduse_waits", 128'(w), 128'(1));
    check("loaduse_bubble", 128'(v), 128'(0));

    // rt of an I-type ALU op is not a source: no stall.
    vec("lw_b", 32'h8C280000, mk(6'h23, 6'h00, init_val(1), init_val(8), 32'h0, 5'd8, 1'b1, 1'b1), 0);
    vec("ori_rt_unused", 32'h34480001, mk(6'h0D, 6'h01, init_val(2), init_val(8), 32'h1, 5'd8, 1'b1, 1'b0), 0);

    // Load-use through rt of a store.
    vec("lw_c", 32'h8C280000, mk(6'h23, 6'h00, init_val(1), init_val(8), 32'h0, 5'd8, 1'b1, 1'b1), 0);
    vec("sw_rt_hazard", 32'hAC280004, mk(6'h2B, 6'h04, init_val(1), init_val(8), 32'h4, 5'd0, 1'b0, 1'b0), 1);

    // Same-cycle writeback to both sources.
    fork
      begin
`ifdef DECODE_WB_BYPASS_EN
        vec("wb_sub", 32'h00843822, mk(6'h00, 6'h22, 32'hDEADBEEF, 32'hDEADBEEF, 32'h3822, 5'd7, 1'b1, 1'b0), 0);
`else
        vec("wb_sub", 32'h00843822, mk(6'h00, 6'h22, 32'hDEADBEEF, 32'hDEADBEEF, 32'h3822, 5'd7, 1'b1, 1'b0), 1);
`endif
      end
      begin
        wb_reg_write = 1'b1; wb_write_reg = 5'd4; wb_write_data = 32'hDEADBEEF;
        @(posedge clock); #1;
        wb_reg_write = 1'b0;
      end
    join

    // Writeback to $0 neither stalls nor leaks into a $0 operand.
    fork
      vec("wb_reg0", 32'h200E0005, mk(6'h08, 6'h05, 32'h0, init_val(14), 32'h5, 5'd14, 1'b1, 1'b0), 0);
      begin
        wb_reg_write = 1'b1; wb_write_reg = 5'd0; wb_write_data = 32'h55555555;
        @(posedge clock); #1;
        wb_reg_write = 1'b0;
      end
    join

    // Execute stall for three cycles, then flush the held instruction.
    repeat (2) @(posedge clock);
    #1;
    check("drained_ex_valid", 128'(ex_valid), 128'(0));
    ex_ready = 1'b0;
    ea = mk(6'h08, 6'h07, init_val(1), init_val(15), 32'h7, 5'd15, 1'b1, 1'b0);
    eb = mk(6'h0D, 6'h3F, init_val(2), init_val(16), 32'hFF, 5'd16, 1'b1, 1'b0);
    send(32'h202F0007, ea, 1'b0, w, v);
    if_valid = 1'b1;
    if_instr = 32'h345000FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_if_ready", 128'(if_ready), 128'(0));
      check("stall_ex_hold", 128'({ex_valid, act}), 128'({1'b1, ea}));
    end
    @(posedge clock); #1;
    flush = 1'b1;
    @(negedge clock);
    check("flush_if_ready", 128'(if_ready), 128'(0));
    @(posedge clock); #1;
    flush = 1'b0;
    ex_ready = 1'b1;
    check("flush_ex_valid", 128'(ex_valid), 128'(0));
    @(negedge clock);
    check("post_flush_if_ready", 128'(if_ready), 128'(1));
    sb.push_back(eb);
    @(posedge clock); #1;
    if_valid = 1'b0;

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
